pwm_sample_sched: RTL and testbench

PWM_SAMPLE_SCHED -- requirements
Module: pwm_sample_sched

---
 rtl/sass_pkg.sv | 15 +
 rtl/voice_avg.sv | 24 ++
 rtl/pwm_sample_sched.sv | 123 ++++++++++++
 tb/tb_pwm_sample_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sass_pkg.sv
// Shared state type and default timing constants for the PWM sample scheduler.
package sass_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    DIVIDE,
    HOLD
  } state_t;

  localparam int         NUM_VOICES      = 4;
  localparam logic [7:0] FRAME_LAST      = 8'd255;
  localparam logic [7:0] GATHER_DEADLINE = 8'd252;

endpackage

// File: rtl/voice_avg.sv
// Combinational floor(acc/nv) for nv = 0..4 using shifts and one constant multiply.
module voice_avg (
  input  logic [9:0] acc,
  input  logic [2:0] nv,
  output logic [7:0] avg
);

  logic [7:0] third;

  // 683/2048 exceeds 1/3 by 1/6144; for acc <= 1020 that never pushes the result past the next integer.
  assign third = 8'((20'(acc) * 20'd683) >> 11);

  always_comb begin
    avg = 8'd0;
    case (nv)
      3'd1:    avg = acc[7:0];
      3'd2:    avg = acc[8:1];
      3'd3:    avg = third;
      3'd4:    avg = acc[9:2];
      default: avg = 8'd0;
    endcase
  end

endmodule

// File: rtl/pwm_sample_sched.sv
// Collects one sample per enabled voice each PWM frame, averages them and
// presents the result to the PWM with a load strobe at the period wrap.
module pwm_sample_sched #(
  parameter int         NUM_VOICES      = sass_pkg::NUM_VOICES,
  parameter logic [7:0] FRAME_LAST      = sass_pkg::FRAME_LAST,
  parameter logic [7:0] GATHER_DEADLINE = sass_pkg::GATHER_DEADLINE
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] sample_i,
  input  logic [3:0]  valid_i,
  input  logic [3:0]  en_i,
  output logic [3:0]  ack_o,
  output logic [7:0]  comb_waveform,
  output logic        ready
);

  import sass_pkg::state_t;
  import sass_pkg::IDLE;
  import sass_pkg::GATHER;
  import sass_pkg::DIVIDE;
  import sass_pkg::HOLD;

  state_t     state, state_next;
  logic [7:0] frame_cnt;
  logic [1:0] ptr, ptr_next;
  logic [9:0] acc, acc_next;
  logic [2:0] nv, nv_next;
  logic [7:0] avg, avg_held;
  logic       cur_en, cur_valid, at_deadline, last_voice, load_point;
  logic       take, voice_done;
  logic [7:0] cur_sample;

  assign cur_en      = en_i[ptr];
  assign cur_valid   = valid_i[ptr];
  assign cur_sample  = sample_i[{ptr, 3'b000} +: 8];
  assign at_deadline = (frame_cnt == GATHER_DEADLINE);
  assign last_voice  = (ptr == 2'(NUM_VOICES - 1));
  // Registered strobe is launched one count early so it is high while frame_cnt == FRAME_LAST.
  assign load_point  = (frame_cnt == FRAME_LAST - 8'd1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_cnt <= 8'd0;
    end else if (frame_cnt == FRAME_LAST) begin
      frame_cnt <= 8'd0;
    end else begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_cnt == 8'd0) state_next = GATHER;
      GATHER:  if (at_deadline || (last_voice && voice_done)) state_next = DIVIDE;
      DIVIDE:  state_next = HOLD;
      HOLD:    if (load_point) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    // At the deadline only the final voice may still be taken; earlier ones are dropped.
    take       = (state == GATHER) && cur_en && cur_valid && (!at_deadline || last_voice);
    voice_done = !cur_en || take;
    ack_o      = 4'b0000;
    if (take) ack_o[ptr] = 1'b1;
    ptr_next = ptr;
    acc_next = acc;
    nv_next  = nv;
    case (state)
      IDLE: begin
        ptr_next = 2'd0;
        acc_next = 10'd0;
        nv_next  = 3'd0;
      end
      GATHER: begin
        if (take) begin
          ptr_next = ptr + 2'd1;
          acc_next = acc + {2'b00, cur_sample};
          nv_next  = nv + 3'd1;
        end else if (!cur_en) begin
          ptr_next = ptr + 2'd1;
        end
      end
      default: ;
    endcase
  end

  voice_avg u_voice_avg (
    .acc (acc),
    .nv  (nv),
    .avg (avg)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr           <= 2'd0;
      acc           <= 10'd0;
      nv            <= 3'd0;
      avg_held      <= 8'd0;
      comb_waveform <= 8'd0;
      ready         <= 1'b0;
    end else begin
      ptr   <= ptr_next;
      acc   <= acc_next;
      nv    <= nv_next;
      ready <= (state == HOLD) && load_point;
      if (state == DIVIDE) avg_held <= avg;
      if ((state == HOLD) && load_point) comb_waveform <= avg_held;
    end
  end

endmodule

// File: tb/tb_pwm_sample_sched.sv
// Frame-level bench: each frame's ack times and average are derived from voice
// arrival times and compared against the scheduler on every cycle.
module tb_pwm_sample_sched;

  localparam int DL = 252;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] sample_i;
  logic [3:0]  valid_i, en_i, ack_o;
  logic [7:0]  comb_waveform;
  logic        ready;

  logic [9:0]  sw_acc;
  logic [2:0]  sw_nv;
  logic [7:0]  sw_avg;

  int         checks = 0;
  int         failures = 0;
  bit         chk_on = 1'b0;
  bit         sweep_on = 1'b0;
  bit         sweep_done = 1'b0;
  int         cur_p;
  int         frame_no = 0;
  logic [3:0] exp_ack;
  logic       exp_ready;
  logic [7:0] exp_wave;
  logic [7:0] wave_model;
  int         lit_avg;
  bit         lit_ack;

  always #5 clk = ~clk;

  pwm_sample_sched dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .sample_i      (sample_i),
    .valid_i       (valid_i),
    .en_i          (en_i),
    .ack_o         (ack_o),
    .comb_waveform (comb_waveform),
    .ready         (ready)
  );

  voice_avg u_avg (
    .acc (sw_acc),
    .nv  (sw_nv),
    .avg (sw_avg)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Single compare process
  always @(negedge clk) begin
    if (chk_on) begin
      check($sformatf("ack_o f=%0d p=%0d", frame_no, cur_p), int'(ack_o), int'(exp_ack));
      check($sformatf("ready f=%0d p=%0d", frame_no, cur_p), int'(ready), int'(exp_ready));
      check($sformatf("comb_waveform f=%0d p=%0d", frame_no, cur_p), int'(comb_waveform), int'(exp_wave));
      if (lit_ack && cur_p >= 1 && cur_p <= 4)
        check($sformatf("literal ack p=%0d", cur_p), int'(ack_o), 1 << (cur_p - 1));
      if (lit_avg >= 0 && cur_p == 255)
        check($sformatf("literal wave f=%0d", frame_no), int'(comb_waveform), lit_avg);
    end
    if (sweep_on)
      check($sformatf("voice_avg acc=%0d nv=%0d", sw_acc, sw_nv), int'(sw_avg),
            (sw_nv == 3'd0) ? 0 : int'(sw_acc) / int'(sw_nv));
  end

  initial begin
    sw_acc = 10'd0;
    sw_nv  = 3'd0;
    for (int nvv = 0; nvv <= 4; nvv++) begin
      for (int a = 0; a <= ((nvv == 0) ? 1020 : 255 * nvv); a++) begin
        @(posedge clk);
        #1;
        sw_acc   = 10'(a);
        sw_nv    = 3'(nvv);
        sweep_on = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    sweep_on   = 1'b0;
    sweep_done = 1'b1;
  end

  // arr[k]: frame count at which voice k raises valid (1023 = never).
  task automatic run_frame(input logic [3:0] en, input logic [3:0][9:0] arr,
                           input logic [3:0][7:0] s, input int lavg, input bit lack,
                           input int reset_at);
    int         ack_cyc[4];
    int         t, a, sum, n;
    bit         done;
    logic [7:0] avg;
    logic [3:0] v;
    t = 1; sum = 0; n = 0; done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ack_cyc[k] = -1;
      if (!done) begin
        if (!en[k]) begin
          if (t >= DL) done = 1'b1;
          else t++;
        end else begin
          a = (int'(arr[k]) > t) ? int'(arr[k]) : t;
          if (a < DL || (a == DL && k == 3)) begin
            ack_cyc[k] = a;
            sum += int'(s[k]);
            n++;
            t = a + 1;
          end else begin
            done = 1'b1;
          end
        end
      end
    end
    avg     = (n == 0) ? 8'd0 : 8'(sum / n);
    lit_avg = lavg;
    lit_ack = lack;
    for (int p = 0; p < 256; p++) begin
      cur_p = p;
      for (int k = 0; k < 4; k++)
        v[k] = (p >= 1) && (p >= int'(arr[k])) && (ack_cyc[k] < 0 || p <= ack_cyc[k]);
      valid_i = v;
      en_i    = en;
      for (int k = 0; k < 4; k++)
        sample_i[8*k +: 8] = v[k] ? s[k] : 8'($urandom);
      exp_ack = 4'b0000;
      for (int k = 0; k < 4; k++)
        if (ack_cyc[k] == p) exp_ack[k] = 1'b1;
      exp_ready = (p == 255);
      if (p == 255) wave_model = avg;
      exp_wave = wave_model;
      if (p == reset_at) begin
        n_rst      = 1'b0;
        exp_ack    = 4'b0000;
        exp_ready  = 1'b0;
        wave_model = 8'd0;
        exp_wave   = 8'd0;
        lit_ack    = 1'b0;
        lit_avg    = -1;
        $display("frame %0d en=%b reset at p=%0d", frame_no, en, p);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        frame_no++;
        return;
      end
      @(posedge clk);
      #1;
    end
    $display("frame %0d en=%b arr=%0d/%0d/%0d/%0d n=%0d avg=%0d", frame_no, en,
             arr[0], arr[1], arr[2], arr[3], n, avg);
    frame_no++;
  endtask

  initial begin
    logic [3:0]       en;
    logic [3:0][9:0]  arr;
    logic [3:0][7:0]  s;
    int               r;
    n_rst      = 1'b0;
    valid_i    = 4'b0000;
    en_i       = 4'b0000;
    sample_i   = 32'd0;
    wave_model = 8'd0;
    exp_ack    = 4'b0000;
    exp_ready  = 1'b0;
    exp_wave   = 8'd0;
    lit_avg    = -1;
    lit_ack    = 1'b0;
    cur_p      = 0;
    repeat (3) @(posedge clk);
    #1;
    n_rst  = 1'b1;
    chk_on = 1'b1;

    run_frame(4'b1111, {10'd1, 10'd1, 10'd1, 10'd1}, {8'd40, 8'd30, 8'd20, 8'd10}, 25, 1'b1, -1);
    run_frame(4'b0101, {10'd1, 10'd1, 10'd1, 10'd1}, {8'd99, 8'd254, 8'd77, 8'd255}, 254, 1'b0, -1);
    run_frame(4'b0111, {10'd1, 10'd1, 10'd1, 10'd1}, {8'd9, 8'd254, 8'd255, 8'd255}, 254, 1'b0, -1);
    run_frame(4'b1111, {10'd1, 10'd1, 10'd1023, 10'd1}, {8'd200, 8'd200, 8'd200, 8'd123}, 123, 1'b0, -1);
    run_frame(4'b0000, {10'd1, 10'd1, 10'd1, 10'd1}, {8'd50, 8'd60, 8'd70, 8'd80}, 0, 1'b0, -1);
    run_frame(4'b1111, {10'd252, 10'd3, 10'd2, 10'd1}, {8'd200, 8'd100, 8'd100, 8'd100}, 125, 1'b0, -1);
    run_frame(4'b1111, {10'd252, 10'd252, 10'd2, 10'd1}, {8'd9, 8'd9, 8'd50, 8'd100}, 75, 1'b0, -1);
    run_frame(4'b1111, {10'd1, 10'd1, 10'd1023, 10'd1}, {8'd250, 8'd250, 8'd250, 8'd250}, -1, 1'b0, 10);
    run_frame(4'b1111, {10'd1, 10'd1, 10'd1, 10'd1}, {8'd6, 8'd3, 8'd2, 8'd1}, 3, 1'b0, -1);

    for (int f = 0; f < 12; f++) begin
      en = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        r = int'($urandom_range(0, 9));
        if (r < 6)      arr[k] = 10'($urandom_range(1, 8));
        else if (r < 8) arr[k] = 10'($urandom_range(240, 255));
        else if (r < 9) arr[k] = 10'($urandom_range(9, 200));
        else            arr[k] = 10'd1023;
        s[k] = 8'($urandom);
      end
      run_frame(en, arr, s, -1, 1'b0, -1);
    end

    chk_on = 1'b0;
    while (!sweep_done) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
